// File: rtl/adc_scan_sched.sv
// Shared-ADC sequencer: periodic masked round-robin scan with one priority
// one-shot request slot, and a per-channel result register file.

module adc_scan_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [11:0] wdata,
  input  logic        clr,
  output logic [11:0] result,
  output logic        fresh
);
  logic [11:0] result_q, result_d;
  logic        fresh_q, fresh_d;

  always_comb begin
    result_d = we ? wdata : result_q;
    // a store landing on the same edge as a clear keeps the flag set
    fresh_d  = we ? 1'b1 : (clr ? 1'b0 : fresh_q);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      result_q <= '0;
      fresh_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      fresh_q  <= fresh_d;
    end

  assign result = result_q;
  assign fresh  = fresh_q;
endmodule

module adc_scan_sched #(
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [7:0]  chan_mask,
  input  logic        req,
  input  logic [2:0]  req_chan,
  output logic        req_ack,
  output logic [11:0] req_data,
  output logic [2:0]  adc_chan,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_result,
  input  logic [2:0]  rd_sel,
  output logic [11:0] rd_data,
  input  logic        rd_clr,
  output logic [7:0]  new_data,
  output logic        scan_done,
  output logic        timeout_err
);
  localparam int NCH = 8;
  localparam int PW  = $clog2(PERIOD);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    per_cnt_q, per_cnt_d;
  logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             pend_q, pend_d, active_q, active_d, is_req_q, is_req_d;
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       cursor_q, cursor_d, chan_q, chan_d;
  logic             start_q, start_d, ack_q, ack_d, done_q, done_d, terr_q, terr_d;
  logic [11:0]      rdata_q, rdata_d;
  logic             wrap, pend_clr, st_we, timed_out;
  logic [2:0]       nxt_ch;
  logic [7:0]       hi_mask;
  logic [NCH-1:0][11:0] result;
  logic [NCH-1:0]   fresh;

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    wait_cnt_d = wait_cnt_q;
    active_d   = active_q;
    is_req_d   = is_req_q;
    mask_d     = mask_q;
    cursor_d   = cursor_q;
    chan_d     = chan_q;
    start_d    = 1'b0;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    terr_d     = terr_q;
    rdata_d    = rdata_q;
    wrap       = 1'b0;
    pend_clr   = 1'b0;
    st_we      = 1'b0;
    timed_out  = 1'b0;

    if (!scan_en) per_cnt_d = '0;
    else if (per_cnt_q == PW'(PERIOD - 1)) begin
      per_cnt_d = '0;
      wrap      = 1'b1;
    end else per_cnt_d = per_cnt_q + 1'b1;

    // lowest latched channel at or above the cursor
    nxt_ch = cursor_q;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask_q[i] && (3'(i) >= cursor_q)) nxt_ch = 3'(i);
    hi_mask = mask_q & (8'hFE << chan_q);

    unique case (state_q)
      IDLE: begin
        if (req) begin
          chan_d   = req_chan;
          is_req_d = 1'b1;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end else if (active_q) begin
          chan_d   = nxt_ch;
          is_req_d = 1'b0;
          start_d  = 1'b1;
          state_d  = ISSUE;
        end else if (pend_q) begin
          pend_clr = 1'b1;
          mask_d   = chan_mask;
          cursor_d = '0;
          active_d = |chan_mask;
          done_d   = ~|chan_mask;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // results become visible in the STORE cycle, so commit on this edge
        if (adc_done || (wait_cnt_q == TW'(TIMEOUT - 1))) begin
          timed_out = !adc_done;
          state_d   = STORE;
          if (timed_out) terr_d = 1'b1;
          if (is_req_q) begin
            ack_d   = 1'b1;
            rdata_d = timed_out ? 12'hFFF : adc_result;
          end else begin
            st_we = !timed_out;
            if (hi_mask == '0) begin
              done_d   = 1'b1;
              active_d = 1'b0;
            end else cursor_d = chan_q + 3'd1;
          end
        end else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      STORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pend_d = scan_en && (wrap || (pend_q && !pend_clr));
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      wait_cnt_q <= '0;
      pend_q     <= 1'b0;
      active_q   <= 1'b0;
      is_req_q   <= 1'b0;
      mask_q     <= '0;
      cursor_q   <= '0;
      chan_q     <= '0;
      start_q    <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      active_q   <= active_d;
      is_req_q   <= is_req_d;
      mask_q     <= mask_d;
      cursor_q   <= cursor_d;
      chan_q     <= chan_d;
      start_q    <= start_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
      rdata_q    <= rdata_d;
    end

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    adc_scan_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (st_we && (chan_q == 3'(g))),
      .wdata (adc_result),
      .clr   (rd_clr && (rd_sel == 3'(g))),
      .result(result[g]),
      .fresh (fresh[g])
    );
  end

  assign rd_data     = result[rd_sel];
  assign new_data    = fresh;
  assign req_ack     = ack_q;
  assign req_data    = rdata_q;
  assign adc_chan    = chan_q;
  assign adc_start   = start_q;
  assign scan_done   = done_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed bench for adc_scan_sched with a small ADC responder model
// (result = 12'h100 + channel, LAT cycles after adc_start).

module tb_adc_scan_sched;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset, scan_en, req, adc_done, rd_clr;
  logic [7:0] chan_mask;
  logic [2:0] req_chan, rd_sel;
  logic [11:0] adc_result;
  logic req_ack, adc_start, scan_done, timeout_err;
  logic [11:0] req_data, rd_data;
  logic [2:0] adc_chan;
  logic [7:0] new_data;

  logic m_done, f_done, m_en, drop_en;
  logic [11:0] m_result, f_result;
  logic [2:0] drop_chan, mch;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  logic [2:0] st_ch[$];
  int st_cyc[$];
  int done_cyc[$];
  int ack_cyc[$];

  adc_scan_sched #(.PERIOD(8), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .chan_mask(chan_mask),
    .req(req), .req_chan(req_chan), .req_ack(req_ack), .req_data(req_data),
    .adc_chan(adc_chan), .adc_start(adc_start), .adc_done(adc_done),
    .adc_result(adc_result), .rd_sel(rd_sel), .rd_data(rd_data), .rd_clr(rd_clr),
    .new_data(new_data), .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign adc_done   = m_done | f_done;
  assign adc_result = f_done ? f_result : m_result;

  // passive recorders, sampled mid-cycle
  always @(negedge clk) begin
    if (adc_start) begin st_ch.push_back(adc_chan); st_cyc.push_back(cyc); end
    if (scan_done) done_cyc.push_back(cyc);
    if (req_ack) ack_cyc.push_back(cyc);
    if (adc_done) last_done_cyc = cyc;
  end

  initial begin
    m_done = 1'b0; m_result = '0; mch = '0;
    forever begin
      @(negedge clk);
      if (adc_start && m_en && !(drop_en && adc_chan == drop_chan)) begin
        mch = adc_chan;
        repeat (LAT) @(posedge clk);
        #1; m_done = 1'b1; m_result = 12'h100 + {9'd0, mch};
        @(posedge clk); #1; m_done = 1'b0;
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (adc_start !== 1'b0 || adc_chan !== 3'd0 || req_ack !== 1'b0 || scan_done !== 1'b0) begin
      failures++; $display("FAIL reset_ctl: start=%b chan=%0d ack=%b done=%b expected all 0", adc_start, adc_chan, req_ack, scan_done);
    end
    checks++;
    if (req_data !== 12'h000 || new_data !== 8'h00 || timeout_err !== 1'b0 || rd_data !== 12'h000) begin
      failures++; $display("FAIL reset_data: req_data=%h new=%h terr=%b rd=%h expected 0", req_data, new_data, timeout_err, rd_data);
    end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_scan();
    int b, db, c0, n;
    b = st_ch.size(); db = done_cyc.size();
    @(posedge clk); #1; chan_mask = 8'h05; scan_en = 1'b1; c0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_start && n < 60);
    checks++;
    if (!adc_start) begin failures++; $display("FAIL scan_start: got no adc_start in %0d cycles, expected one", n); end
    @(posedge clk); #1; scan_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!scan_done && n < 200);
    checks++;
    if (!scan_done) begin failures++; $display("FAIL scan_done_wait: got no scan_done in %0d cycles, expected one", n); end
    repeat (20) @(negedge clk);
    checks++;
    if (st_cyc.size() < b + 1 || st_cyc[b] - c0 != 10) begin
      failures++; $display("FAIL scan_latency: got first start at +%0d, expected +10", (st_cyc.size() > b) ? st_cyc[b] - c0 : -1);
    end
    checks++;
    if (st_ch.size() != b + 2 || st_ch[b] !== 3'd0 || st_ch[b+1] !== 3'd2) begin
      failures++; $display("FAIL scan_order: got %0d starts, expected 2 (ch0, ch2)", st_ch.size() - b);
    end
    checks++;
    if (done_cyc.size() - db != 1) begin failures++; $display("FAIL scan_done_count: got %0d, expected 1", done_cyc.size() - db); end
    checks++;
    if (new_data !== 8'h05) begin failures++; $display("FAIL scan_new_data: got %h, expected 05", new_data); end
    rd_sel = 3'd0; #1;
    checks++;
    if (rd_data !== 12'h100) begin failures++; $display("FAIL scan_rd0: got %h, expected 100", rd_data); end
    rd_sel = 3'd2; #1;
    checks++;
    if (rd_data !== 12'h102) begin failures++; $display("FAIL scan_rd2: got %h, expected 102", rd_data); end
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL scan_terr: got %b, expected 0", timeout_err); end
  endtask

  task automatic test_req_idle();
    int b, n;
    b = st_ch.size();
    @(posedge clk); #1; req = 1'b1; req_chan = 3'd6;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (adc_start !== 1'b1 || adc_chan !== 3'd6) begin
      failures++; $display("FAIL req_issue: got start=%b chan=%0d, expected start=1 chan=6", adc_start, adc_chan);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ack && n < 40);
    checks++;
    if (req_ack !== 1'b1 || req_data !== 12'h106) begin
      failures++; $display("FAIL req_ack: got ack=%b data=%h, expected ack=1 data=106", req_ack, req_data);
    end
    checks++;
    if (cyc - last_done_cyc != 1) begin failures++; $display("FAIL req_ack_lag: got %0d cycles after adc_done, expected 1", cyc - last_done_cyc); end
    req = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (st_ch.size() != b + 1 || new_data[6] !== 1'b0) begin
      failures++; $display("FAIL req_single: got %0d starts new6=%b, expected 1 start new6=0", st_ch.size() - b, new_data[6]);
    end
  endtask

  task automatic test_req_midscan();
    int b, ab, n;
    @(posedge clk); #1; rd_sel = 3'd0; rd_clr = 1'b1;
    @(posedge clk); #1; rd_sel = 3'd2;
    @(posedge clk); #1; rd_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (new_data !== 8'h00) begin failures++; $display("FAIL rd_clr_basic: got %h, expected 00", new_data); end
    b = st_ch.size(); ab = ack_cyc.size();
    @(posedge clk); #1; chan_mask = 8'h05; scan_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_start && n < 60);
    @(posedge clk); #1; req = 1'b1; req_chan = 3'd5; scan_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ack && n < 60);
    checks++;
    if (req_ack !== 1'b1 || req_data !== 12'h105) begin
      failures++; $display("FAIL mid_ack: got ack=%b data=%h, expected ack=1 data=105", req_ack, req_data);
    end
    req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!scan_done && n < 100);
    repeat (10) @(negedge clk);
    checks++;
    if (st_ch.size() != b + 3 || st_ch[b] !== 3'd0 || st_ch[b+1] !== 3'd5 || st_ch[b+2] !== 3'd2) begin
      failures++; $display("FAIL mid_order: got %0d starts, expected 3 (ch0, ch5, ch2)", st_ch.size() - b);
    end
    checks++;
    if (new_data !== 8'h05 || ack_cyc.size() - ab != 1) begin
      failures++; $display("FAIL mid_flags: got new=%h acks=%0d, expected new=05 acks=1", new_data, ack_cyc.size() - ab);
    end
    rd_sel = 3'd5; #1;
    checks++;
    if (rd_data !== 12'h000) begin failures++; $display("FAIL mid_rd5: got %h, expected 000", rd_data); end
  endtask

  task automatic test_timeout();
    int b, s, n;
    @(posedge clk); #1; rd_sel = 3'd0; rd_clr = 1'b1;
    @(posedge clk); #1; rd_sel = 3'd2;
    @(posedge clk); #1; rd_clr = 1'b0; drop_en = 1'b1; drop_chan = 3'd0;
    b = st_ch.size();
    chan_mask = 8'h05; scan_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_start && n < 60);
    s = cyc;
    @(posedge clk); #1; scan_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 40);
    checks++;
    if (timeout_err !== 1'b1 || cyc - s != 11) begin
      failures++; $display("FAIL to_timing: got terr=%b at +%0d after start, expected 1 at +11", timeout_err, cyc - s);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!scan_done && n < 60);
    repeat (5) @(negedge clk);
    drop_en = 1'b0;
    checks++;
    if (st_ch.size() != b + 2 || st_ch[b] !== 3'd0 || st_ch[b+1] !== 3'd2) begin
      failures++; $display("FAIL to_order: got %0d starts, expected 2 (ch0, ch2)", st_ch.size() - b);
    end
    checks++;
    if (new_data !== 8'h04) begin failures++; $display("FAIL to_new_data: got %h, expected 04", new_data); end
    rd_sel = 3'd0; #1;
    checks++;
    if (rd_data !== 12'h100) begin failures++; $display("FAIL to_rd0: got %h, expected 100", rd_data); end
  endtask

  task automatic test_rdclr_collision();
    int n;
    @(posedge clk); #1; rd_sel = 3'd2; rd_clr = 1'b1;
    @(posedge clk); #1; rd_clr = 1'b0; chan_mask = 8'h04; scan_en = 1'b1;
    @(negedge clk);
    checks++;
    if (new_data[2] !== 1'b0) begin failures++; $display("FAIL col_pre: got new2=%b, expected 0", new_data[2]); end
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_start && n < 60);
    @(posedge clk); #1; scan_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_done && n < 30);
    rd_sel = 3'd2; rd_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (new_data[2] !== 1'b1 || scan_done !== 1'b1) begin
      failures++; $display("FAIL col_store_wins: got new2=%b done=%b, expected 1 1", new_data[2], scan_done);
    end
    @(posedge clk); #1; rd_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (new_data[2] !== 1'b0 || rd_data !== 12'h102) begin
      failures++; $display("FAIL col_clear: got new2=%b rd=%h, expected 0 102", new_data[2], rd_data);
    end
  endtask

  task automatic test_mask_zero();
    int b, db, c0;
    bit bad;
    b = st_ch.size(); db = done_cyc.size();
    @(posedge clk); #1; chan_mask = 8'h00; scan_en = 1'b1; c0 = cyc;
    repeat (36) @(posedge clk);
    #1; scan_en = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cyc.size() - db != 4 || st_ch.size() != b) begin
      failures++; $display("FAIL m0_count: got %0d done %0d starts, expected 4 0", done_cyc.size() - db, st_ch.size() - b);
    end
    bad = (done_cyc.size() < db + 4) || (done_cyc[db] - c0 != 9);
    for (int k = 1; k < 4 && !bad; k++)
      if (done_cyc[db+k] - done_cyc[db+k-1] != 8) bad = 1'b1;
    checks++;
    if (bad) begin failures++; $display("FAIL m0_spacing: got first at +%0d, expected +9 then every 8", (done_cyc.size() > db) ? done_cyc[db] - c0 : -1); end
  endtask

  task automatic test_reset_mid();
    int b, ab, n;
    m_en = 1'b0;
    @(posedge clk); #1; chan_mask = 8'h08; scan_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_start && n < 60);
    @(posedge clk); #1;
    checks++;
    if (adc_chan !== 3'd3 || timeout_err !== 1'b1) begin
      failures++; $display("FAIL rm_pre: got chan=%0d terr=%b, expected 3 1", adc_chan, timeout_err);
    end
    reset = 1'b1; scan_en = 1'b0; rd_sel = 3'd2; #1;
    checks++;
    if (adc_chan !== 3'd0 || adc_start !== 1'b0 || req_ack !== 1'b0 || scan_done !== 1'b0) begin
      failures++; $display("FAIL rm_ctl: got chan=%0d start=%b ack=%b done=%b, expected 0", adc_chan, adc_start, req_ack, scan_done);
    end
    checks++;
    if (req_data !== 12'h000 || timeout_err !== 1'b0 || rd_data !== 12'h000 || new_data !== 8'h00) begin
      failures++; $display("FAIL rm_data: got req_data=%h terr=%b rd=%h new=%h, expected 0", req_data, timeout_err, rd_data, new_data);
    end
    @(posedge clk); #1; reset = 1'b0;
    b = st_ch.size(); ab = ack_cyc.size();
    repeat (2) @(posedge clk);
    #1; f_done = 1'b1; f_result = 12'hABC;
    @(posedge clk); #1; f_done = 1'b0;
    repeat (10) @(negedge clk);
    rd_sel = 3'd3; #1;
    checks++;
    if (ack_cyc.size() != ab || st_ch.size() != b || new_data !== 8'h00 || rd_data !== 12'h000) begin
      failures++; $display("FAIL rm_stray_done: got acks=%0d starts=%0d new=%h rd3=%h, expected 0 0 00 000", ack_cyc.size() - ab, st_ch.size() - b, new_data, rd_data);
    end
    m_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; scan_en = 1'b0; chan_mask = '0; req = 1'b0; req_chan = '0;
    rd_sel = '0; rd_clr = 1'b0; f_done = 1'b0; f_result = '0;
    m_en = 1'b1; drop_en = 1'b0; drop_chan = '0;
    test_reset();
    test_scan();
    test_req_idle();
    test_req_midscan();
    test_timeout();
    test_rdclr_collision();
    test_mask_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
